// File: rtl/pixel_job_scheduler_if.sv
// rtl/pixel_job_scheduler_if.sv - job request/grant/done bundle between frame control, scheduler and tracer cores
//
// Signals:
//   frame_start       one-cycle pulse requesting a new frame render
//   core_req          bit i: core i idle and wants a job
//   core_done         bit i: one-cycle pulse, core i finished its pixel
//   core_grant        one-hot (or zero) one-cycle grant
//   job_valid         high exactly when core_grant != 0
//   job_x / job_y     pixel coordinates of the granted job
//   busy              frame in progress (dispatching or draining)
//   frame_done        one-cycle pulse when the frame is complete
//   jobs_outstanding  jobs granted but not yet done
//   frame_cycles      (SCHED_PERF_EN only) cycles spent on the last frame
// Modports: master = frame control + core array, slave = scheduler.
interface pixel_job_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int COORD_W   = 9,
  parameter int CNT_W     = $clog2(NUM_CORES + 1)
);
  logic                 frame_start;
  logic [NUM_CORES-1:0] core_req;
  logic [NUM_CORES-1:0] core_done;
  logic [NUM_CORES-1:0] core_grant;
  logic                 job_valid;
  logic [COORD_W-1:0]   job_x;
  logic [COORD_W-1:0]   job_y;
  logic                 busy;
  logic                 frame_done;
  logic [CNT_W-1:0]     jobs_outstanding;
`ifdef SCHED_PERF_EN
  logic [31:0]          frame_cycles;
`endif

  modport master (
    output frame_start, core_req, core_done,
    input  core_grant, job_valid, job_x, job_y, busy, frame_done, jobs_outstanding
`ifdef SCHED_PERF_EN
    , input frame_cycles
`endif
  );

  modport slave (
    input  frame_start, core_req, core_done,
    output core_grant, job_valid, job_x, job_y, busy, frame_done, jobs_outstanding
`ifdef SCHED_PERF_EN
    , output frame_cycles
`endif
  );
endinterface

// File: rtl/pixel_job_scheduler.sv
// rtl/pixel_job_scheduler.sv - round-robin per-pixel ray job dispatcher with in-flight tracking
//
// Hands out raster-order (x,y) jobs for one frame to NUM_CORES tracer cores and
// pulses frame_done once every granted job has reported back.
// Ports:
//   CLK100MHZ  system clock, rising edge
//   ck_rst_    asynchronous active-low reset
//   bus        pixel_job_scheduler_if.slave (see interface file for signals)
// Optional feature macro: SCHED_PERF_EN adds bus.frame_cycles, the number of
// cycles spent in DISPATCH+DRAIN for the most recently completed frame.
module pixel_job_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int H_RES     = 320,
  parameter int V_RES     = 240,
  parameter int COORD_W   = 9,
  parameter int CNT_W     = $clog2(NUM_CORES + 1)
) (
  input  logic                    CLK100MHZ,
  input  logic                    ck_rst_,
  pixel_job_scheduler_if.slave    bus
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [PTR_W:0]     NC_P     = (PTR_W+1)'(NUM_CORES);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(NUM_CORES - 1);
  localparam logic [CNT_W-1:0]   OUT_MAX  = CNT_W'(NUM_CORES);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_RES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  logic [NUM_CORES-1:0] r_grant;
  logic                 r_valid;
  logic [COORD_W-1:0]   r_x, r_y;
  logic [COORD_W-1:0]   r_job_x, r_job_y;
  logic [PTR_W-1:0]     r_rr;
  logic [CNT_W-1:0]     r_out;
  logic                 r_busy;
  logic                 r_frame_done;
`ifdef SCHED_PERF_EN
  logic [31:0]          r_cyc;
  logic [31:0]          r_frame_cycles;
`endif

  logic [NUM_CORES-1:0] w_eligible;
  logic                 w_found;
  logic [PTR_W-1:0]     w_win;
  logic [PTR_W:0]       w_sum;
  logic [PTR_W-1:0]     w_idx;
  logic                 w_grant_now;
  logic                 w_last;
  logic [CNT_W-1:0]     w_pop;
  logic [CNT_W:0]       w_out_add;
  logic [CNT_W-1:0]     w_out_next;

  // A core granted last cycle is masked so a late-dropped request is not re-granted.
  assign w_eligible = bus.core_req & ~r_grant;

  // Round-robin search starting at r_rr, wrapping at NUM_CORES.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_sum = {1'b0, r_rr} + (PTR_W+1)'(i);
      if (w_sum >= NC_P) w_sum = w_sum - NC_P;
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && w_eligible[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Grants are also held back at the in-flight ceiling so the counter cannot exceed NUM_CORES.
  assign w_grant_now = (r_state == S_DISPATCH) && (r_out < OUT_MAX) && w_found;
  assign w_last      = (r_x == X_LAST) && (r_y == Y_LAST);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_pop = w_pop + {{(CNT_W-1){1'b0}}, bus.core_done[i]};
    end
  end

  // Grant and done combine arithmetically; excess done pulses saturate at zero.
  always_comb begin
    w_out_add = {1'b0, r_out} + {{CNT_W{1'b0}}, w_grant_now};
    if ({1'b0, w_pop} > w_out_add) w_out_next = '0;
    else                           w_out_next = CNT_W'(w_out_add - {1'b0, w_pop});
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      r_state        <= S_IDLE;
      r_grant        <= '0;
      r_valid        <= 1'b0;
      r_x            <= '0;
      r_y            <= '0;
      r_job_x        <= '0;
      r_job_y        <= '0;
      r_rr           <= '0;
      r_out          <= '0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
`ifdef SCHED_PERF_EN
      r_cyc          <= '0;
      r_frame_cycles <= '0;
`endif
    end else begin
      r_out   <= w_out_next;
      r_grant <= '0;
      r_valid <= 1'b0;

      if (w_grant_now) begin
        r_grant <= NUM_CORES'(1) << w_win;
        r_valid <= 1'b1;
        r_job_x <= r_x;
        r_job_y <= r_y;
        r_rr    <= (w_win == PTR_LAST) ? '0 : w_win + 1'b1;
        if (!w_last) begin
          if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.frame_start) begin
            r_state <= S_DISPATCH;
            r_busy  <= 1'b1;
            r_x     <= '0;
            r_y     <= '0;
`ifdef SCHED_PERF_EN
            r_cyc   <= '0;
`endif
          end
        end
        S_DISPATCH: begin
`ifdef SCHED_PERF_EN
          r_cyc <= r_cyc + 32'd1;
`endif
          if (w_grant_now && w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
`ifdef SCHED_PERF_EN
          r_cyc <= r_cyc + 32'd1;
`endif
          if ((r_out == '0) && (r_grant == '0)) begin
            r_state      <= S_DONE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_frame_done <= 1'b0;
`ifdef SCHED_PERF_EN
          r_frame_cycles <= r_cyc;
`endif
        end
      endcase
    end
  end

  assign bus.core_grant       = r_grant;
  assign bus.job_valid        = r_valid;
  assign bus.job_x            = r_job_x;
  assign bus.job_y            = r_job_y;
  assign bus.busy             = r_busy;
  assign bus.frame_done       = r_frame_done;
  assign bus.jobs_outstanding = r_out;
`ifdef SCHED_PERF_EN
  assign bus.frame_cycles     = r_frame_cycles;
`endif

endmodule
